seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for the board's 8-digit common-anode seven-segment display.
//  Consumes the six decoded time digits (hrs/min/sec tens and ones, 6-bit each) produced downstream of the clock core.
//  Scans one digit at a time, lights dp separators, optionally blinks selected digits for time-set mode.
//  Output pins go directly to the FPGA anode/cathode pins.
// PARAMETERS
//  SCAN_DIV   100_000     clk cycles each digit stays lit (1 ms at 100 MHz)
//  BLINK_DIV  50_000_000  clk cycles per blink phase (0.5 s at 100 MHz)
// PORTS
//  clk        in   1  system clock, 100 MHz
//  rst        in   1  asynchronous, active-high reset
//  en         in   1  display enable; 0 = all digits dark, scan frozen
//  hrs_tens   in   6  digit value, shown on an[5]
//  hrs_ones   in   6  digit value, shown on an[4]
//  min_tens   in   6  digit value, shown on an[3]
//  min_ones   in   6  digit value, shown on an[2]
//  sec_tens   in   6  digit value, shown on an[1]
//  sec_ones   in   6  digit value, shown on an[0]
//  blink_mask in   6  bit i=1: digit i (same index as an[i]) blanks during blink phase 1
//  an         out  8  anodes, active-low, one-hot-low
//  seg        out  7  cathodes {g,f,e,d,c,b,a}, active-low
//  dp         out  1  decimal point, active-low
// BEHAVIOUR
//  - Reset (async, immediate): an=8'hFF, seg=7'h7F, dp=1, digit index=0, scan cnt=0, blink cnt=0, blink phase=0.
//  - scan cnt counts 0..SCAN_DIV-1 while en=1. At terminal count it wraps to 0; index advances 0,1,2,3,4,5,0.
//  - an[7:6] are always 1. Indices 6/7 never occur.
//  - blink cnt counts 0..BLINK_DIV-1 regardless of en. At terminal count it wraps and phase toggles.
//  - Outputs are registered from the current index, digit value, phase and en. Latency is 1 clk.
//  - Inputs are not latched. A digit value change shows on the next cycle that digit is selected.
//  - Digit decode, active-low {g..a}:
//    0=1000000  1=1111001  2=0100100  3=0110000  4=0011001
//    5=0010010  6=0000010  7=1111000  8=0000000  9=0010000
//  - Any value 10..63 decodes to a dash, 7'b0111111 (only g lit).
//  - dp=0 while index 2 or 4 is lit (separators after min_ones and hrs_ones). Otherwise dp=1.
//  - Blank digit (phase=1 and blink_mask[index]=1): an=8'hFF, seg=7'h7F, dp=1. The slot time is still consumed.
//  - en=0: next edge drives an=8'hFF, seg=7'h7F, dp=1. Scan cnt and index hold.
//    When en returns to 1, the held digit resumes for its remaining count.
//  - Reset mid-scan: outputs blank immediately. First edge after release lights index 0 (an=8'hFE).
//  - Exactly one anode is low at any time, or none. Never two.
// TESTING  (SCAN_DIV=4, BLINK_DIV=32)
//  1 Reset: rst=1 mid-run -> an=FF, seg=7F, dp=1 with no clk edge. Release, en=1 -> edge 1 gives an=FE.
//  2 Scan: digits h=1,2 m=3,4 s=5,6 -> an=FE seg=0000010 for 4 clks, then an=FD seg=0010010 for 4 clks,
//    ..., an=DF seg=1111001; then wraps to FE. dp=0 only when an=FB or an=EF.
//  3 Dash: min_ones=12 -> while an=FB, seg=0111111 and dp=0.
//  4 Blink: blink_mask=6'b110000 -> an=DF/EF slots all-high during phase 1 (32 clks), lit during phase 0.
//    Other digits unaffected.
//  5 Enable: drop en mid-slot of index 3 -> an=FF next clk. Re-raise en after 10 clks -> an=F7 for the
//    remaining count only.
//  6 Live update: change sec_ones 5->7 while an=FD is lit -> seg unchanged. Next FE slot shows 1111000.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver_if
//  Brief    : Digit values, enable/blink controls and display pin bundle for
//             the seven-segment scan driver.
//  Revision : 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if;
    logic       en;
    logic [5:0] hrs_tens;
    logic [5:0] hrs_ones;
    logic [5:0] min_tens;
    logic [5:0] min_ones;
    logic [5:0] sec_tens;
    logic [5:0] sec_ones;
    logic [5:0] blink_mask;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output en, hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones,
               blink_mask,
        input  an, seg, dp
    );

    modport slave (
        input  en, hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones,
               blink_mask,
        output an, seg, dp
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Brief    : Time-multiplexed driver for an 8-digit common-anode display,
//             showing six time digits with dp separators and digit blinking.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned BLINK_DIV = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);

    localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [2:0]         IDX_LAST   = 3'd5;

    localparam logic [7:0] AN_OFF   = 8'hFF;
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 is shown as a dash
    function automatic logic [6:0] decode_digit(input logic [5:0] value);
        logic [6:0] pattern;
        case (value)
            6'd0:    pattern = 7'b1000000;
            6'd1:    pattern = 7'b1111001;
            6'd2:    pattern = 7'b0100100;
            6'd3:    pattern = 7'b0110000;
            6'd4:    pattern = 7'b0011001;
            6'd5:    pattern = 7'b0010010;
            6'd6:    pattern = 7'b0000010;
            6'd7:    pattern = 7'b1111000;
            6'd8:    pattern = 7'b0000000;
            6'd9:    pattern = 7'b0010000;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q,     phase_d;
    logic [2:0]         idx_q,       idx_d;
    logic [7:0]         an_q,        an_d;
    logic [6:0]         seg_q,       seg_d;
    logic               dp_q,        dp_d;

    logic [5:0]         cur_digit;
    logic               cur_blink;
    logic               blank;

    // Current digit and its blink-mask bit, both indexed like the anodes
    always_comb begin
        cur_digit = 6'd0;
        cur_blink = 1'b0;
        case (idx_q)
            3'd0: begin cur_digit = bus.sec_ones; cur_blink = bus.blink_mask[0]; end
            3'd1: begin cur_digit = bus.sec_tens; cur_blink = bus.blink_mask[1]; end
            3'd2: begin cur_digit = bus.min_ones; cur_blink = bus.blink_mask[2]; end
            3'd3: begin cur_digit = bus.min_tens; cur_blink = bus.blink_mask[3]; end
            3'd4: begin cur_digit = bus.hrs_ones; cur_blink = bus.blink_mask[4]; end
            3'd5: begin cur_digit = bus.hrs_tens; cur_blink = bus.blink_mask[5]; end
            default: begin cur_digit = 6'd0; cur_blink = 1'b0; end
        endcase
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q;
        idx_d      = idx_q;
        if (bus.en) begin
            if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_d = '0;
                idx_d      = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
        end
    end

    // Blink timebase free-runs so blinking stays steady across enable toggles
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_comb begin
        blank = !bus.en || (phase_q && cur_blink);
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = decode_digit(cur_digit);
            dp_d  = !((idx_q == 3'd2) || (idx_q == 3'd4));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            idx_q       <= 3'd0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Brief    : Randomised and directed bench for seg7_scan_driver against a
//             count-based reference model of the scan and blink timebases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // dig[i] is the value shown on an[i]
    logic [5:0] dig [6];
    logic [5:0] mask;
    logic       en;

    assign bus.sec_ones   = dig[0];
    assign bus.sec_tens   = dig[1];
    assign bus.min_ones   = dig[2];
    assign bus.min_tens   = dig[3];
    assign bus.hrs_ones   = dig[4];
    assign bus.hrs_tens   = dig[5];
    assign bus.blink_mask = mask;
    assign bus.en         = en;

    // Model state: enabled cycles and total cycles since reset release
    int en_cyc = 0;
    int tot    = 0;

    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    int passed = 0;
    int total  = 0;

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    function automatic logic [6:0] seg_ref(input logic [5:0] v);
        if (v < 6'd10) return seg_tbl[v];
        return 7'b0111111;
    endfunction

    function automatic int m_idx();
        return (en_cyc / SCAN_DIV) % 6;
    endfunction

    function automatic int m_cnt();
        return en_cyc % SCAN_DIV;
    endfunction

    // Predict what the next edge shows, then advance one clock
    task automatic step();
        int idx;
        bit ph;
        idx = m_idx();
        ph  = ((tot / BLINK_DIV) % 2) == 1;
        if (!en || (ph && mask[idx])) begin
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else begin
            exp_an  = ~(8'd1 << idx);
            exp_seg = seg_ref(dig[idx]);
            exp_dp  = (idx == 2 || idx == 4) ? 1'b0 : 1'b1;
        end
        @(posedge clk);
        if (en) en_cyc++;
        tot++;
        #1;
    endtask

    task automatic set_digits(input int h1, h0, m1, m0, s1, s0);
        dig[5] = 6'(h1); dig[4] = 6'(h0); dig[3] = 6'(m1);
        dig[2] = 6'(m0); dig[1] = 6'(s1); dig[0] = 6'(s0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if ({bus.an, bus.seg, bus.dp} !== {8'hFF, 7'h7F, 1'b1})
            $display("FAIL reset_async: an=%h seg=%b dp=%b want an=ff seg=1111111 dp=1",
                     bus.an, bus.seg, bus.dp);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        en_cyc = 0;
        tot    = 0;
    endtask

    task automatic test_reset();
        en = 1'b0;
        mask = 6'd0;
        set_digits(1, 2, 3, 4, 5, 6);
        do_reset();
        // Run partway into a slot, then reset mid-scan while a digit is lit
        en = 1'b1;
        repeat (6) step();
        total++;
        if (bus.an === 8'hFF)
            $display("FAIL reset_prelit: an=%h want a lit digit", bus.an);
        else passed++;
        do_reset();
        step();
        total++;
        if ({bus.an, bus.seg, bus.dp} !== {8'hFE, 7'b0000010, 1'b1})
            $display("FAIL reset_first_edge: an=%h seg=%b dp=%b want an=fe seg=0000010 dp=1",
                     bus.an, bus.seg, bus.dp);
        else passed++;
    endtask

    task automatic test_scan();
        int lit_fe;
        lit_fe = 0;
        set_digits(1, 2, 3, 4, 5, 6);
        mask = 6'd0;
        en   = 1'b1;
        for (int i = 0; i < 56; i++) begin
            step();
            total++;
            if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp})
                $display("FAIL scan cyc%0d: an=%h seg=%b dp=%b want an=%h seg=%b dp=%b",
                         i, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
            else passed++;
            if (bus.an === 8'hFE) lit_fe++;
        end
        // 56 cycles from slot offset 1 covers two full rotations of digit 0
        total++;
        if (lit_fe < 2 * SCAN_DIV - 1)
            $display("FAIL scan_wrap: fe_cycles=%0d want >=%0d", lit_fe, 2 * SCAN_DIV - 1);
        else passed++;
    endtask

    task automatic test_dash();
        int seen;
        seen = 0;
        dig[2] = 6'd12;
        for (int i = 0; i < 30; i++) begin
            step();
            total++;
            if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp})
                $display("FAIL dash cyc%0d: an=%h seg=%b dp=%b want an=%h seg=%b dp=%b",
                         i, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
            else passed++;
            if (bus.an === 8'hFB && bus.seg === 7'b0111111 && bus.dp === 1'b0) seen++;
        end
        total++;
        if (seen == 0)
            $display("FAIL dash_seen: dash cycles=%0d want >0", seen);
        else passed++;
        dig[2] = 6'd4;
    endtask

    task automatic test_blink();
        int lit5;
        lit5 = 0;
        mask = 6'b110000;
        for (int i = 0; i < 4 * BLINK_DIV; i++) begin
            step();
            total++;
            if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp})
                $display("FAIL blink cyc%0d: an=%h seg=%b dp=%b want an=%h seg=%b dp=%b",
                         i, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
            else passed++;
            if (bus.an === 8'hDF) lit5++;
        end
        total++;
        if (lit5 == 0)
            $display("FAIL blink_lit_phase0: df_cycles=%0d want >0", lit5);
        else passed++;
        mask = 6'd0;
    endtask

    task automatic test_enable();
        int f7;
        int rem;
        f7 = 0;
        mask = 6'd0;
        en   = 1'b1;
        for (int i = 0; i < 40 && !(m_idx() == 3 && m_cnt() == 2); i++) step();
        rem = SCAN_DIV - m_cnt();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if ({bus.an, bus.seg, bus.dp} !== {8'hFF, 7'h7F, 1'b1})
                $display("FAIL enable_off cyc%0d: an=%h seg=%b dp=%b want an=ff seg=1111111 dp=1",
                         i, bus.an, bus.seg, bus.dp);
            else passed++;
        end
        en = 1'b1;
        for (int i = 0; i < SCAN_DIV + 1; i++) begin
            step();
            total++;
            if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp})
                $display("FAIL enable_resume cyc%0d: an=%h seg=%b dp=%b want an=%h seg=%b dp=%b",
                         i, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
            else passed++;
            if (bus.an === 8'hF7) f7++;
        end
        total++;
        if (f7 != rem)
            $display("FAIL enable_remaining: f7_cycles=%0d want %0d", f7, rem);
        else passed++;
    endtask

    task automatic test_live_update();
        logic [6:0] seg_before;
        mask = 6'd0;
        en   = 1'b1;
        set_digits(1, 2, 3, 4, 6, 5);
        for (int i = 0; i < 40 && m_idx() != 1; i++) step();
        step();
        seg_before = bus.seg;
        dig[0] = 6'd7;
        step();
        total++;
        if ({bus.an, bus.seg} !== {8'hFD, seg_before})
            $display("FAIL live_hold: an=%h seg=%b want an=fd seg=%b", bus.an, bus.seg, seg_before);
        else passed++;
        for (int i = 0; i < 40 && m_idx() != 0; i++) step();
        step();
        total++;
        if ({bus.an, bus.seg} !== {8'hFE, 7'b1111000})
            $display("FAIL live_update: an=%h seg=%b want an=fe seg=1111000", bus.an, bus.seg);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int d = 0; d < 6; d++)
                    dig[d] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 9))
                                                          : 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 15) == 0) mask = 6'($urandom_range(0, 63));
            en = ($urandom_range(0, 9) != 0);
            step();
            total++;
            if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp})
                $display("FAIL random cyc%0d: an=%h seg=%b dp=%b want an=%h seg=%b dp=%b",
                         i, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
            else passed++;
            total++;
            if ($countones(~bus.an) > 1)
                $display("FAIL random_onehot cyc%0d: an=%h want at most one low", i, bus.an);
            else passed++;
        end
    endtask

    initial begin
        en = 1'b0;
        mask = 6'd0;
        set_digits(0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({bus.an, bus.seg, bus.dp} !== {8'hFF, 7'h7F, 1'b1})
            $display("FAIL reset_initial: an=%h seg=%b dp=%b want an=ff seg=1111111 dp=1",
                     bus.an, bus.seg, bus.dp);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        en_cyc = 0;
        tot    = 0;

        test_reset();
        test_scan();
        test_dash();
        test_blink();
        test_enable();
        test_live_update();
        test_random();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
